// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw keyboard lines, checks each
// 11-bit frame and decodes make/break/extended prefixes into a held scancode level.
module ps2_scancode_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 2500
) (
   input  logic       reset,
   input  logic       clkdiv4,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic       valid,
   output logic       key_up,
   output logic       extended,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          filt;
   logic [FW-1:0] fcnt;
   logic          fall;
   logic [1:0]    state;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          par;
   logic [TW-1:0] tcnt;
   logic          brk, ext;

   // Odd parity over data and parity bit, plus a high stop bit.
   function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic stop);
      return (^{d, p}) & stop;
   endfunction

   // Both lines idle high, so the synchronisers reset to 1.
   always_ff @(posedge clkdiv4 or posedge reset) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Filtered clock flips after FILTER_LEN consecutive differing samples; fall is registered.
   always_ff @(posedge clkdiv4 or posedge reset) begin
      if (reset) begin
         filt <= 1'b1;
         fcnt <= '0;
         fall <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s2 == filt) begin
            fcnt <= '0;
         end else if (fcnt == FILT_LAST) begin
            filt <= clk_s2;
            fcnt <= '0;
            fall <= filt;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clkdiv4) begin
      if (fall && state == DATA)
         shreg <= {dat_s2, shreg[7:1]};
      if (fall && state == PARITY)
         par <= dat_s2;
   end

   always_ff @(posedge clkdiv4 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bitcnt    <= '0;
         tcnt      <= '0;
         brk       <= 1'b0;
         ext       <= 1'b0;
         scancode  <= 8'h00;
         extended  <= 1'b0;
         valid     <= 1'b0;
         key_up    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         key_up    <= 1'b0;
         frame_err <= 1'b0;
         if (state != IDLE && !fall && tcnt == TO_LAST) begin
            // Abandoned partial frame: prefixes no longer belong to a known sequence.
            state     <= IDLE;
            tcnt      <= '0;
            frame_err <= 1'b1;
            brk       <= 1'b0;
            ext       <= 1'b0;
         end else begin
            if (state == IDLE || fall)
               tcnt <= '0;
            else
               tcnt <= tcnt + 1'b1;
            if (fall) begin
               case (state)
                  IDLE: begin
                     if (!dat_s2) begin
                        state  <= DATA;
                        bitcnt <= '0;
                     end
                  end
                  DATA: begin
                     bitcnt <= bitcnt + 1'b1;
                     if (bitcnt == 3'd7)
                        state <= PARITY;
                  end
                  PARITY: state <= STOP;
                  STOP: begin
                     state <= IDLE;
                     if (!frame_ok(shreg, par, dat_s2)) begin
                        frame_err <= 1'b1;
                     end else if (shreg == 8'hF0) begin
                        brk <= 1'b1;
                     end else if (shreg == 8'hE0) begin
                        ext <= 1'b1;
                     end else if (brk) begin
                        key_up <= 1'b1;
                        brk    <= 1'b0;
                        ext    <= 1'b0;
                     end else begin
                        scancode <= shreg;
                        extended <= ext;
                        valid    <= 1'b1;
                        ext      <= 1'b0;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: table of whole frames plus hand-written
// glitch, timeout and mid-frame reset sequences.
module tb_ps2_scancode_rx;

   localparam int TIMEOUT = 2500;

   logic       reset;
   logic       clkdiv4;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scancode;
   logic       valid, key_up, extended, frame_err;

   ps2_scancode_rx #(.FILTER_LEN(4), .TIMEOUT(TIMEOUT)) dut (
      .reset     (reset),
      .clkdiv4   (clkdiv4),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .scancode  (scancode),
      .valid     (valid),
      .key_up    (key_up),
      .extended  (extended),
      .frame_err (frame_err)
   );

   initial clkdiv4 = 1'b0;
   always #5 clkdiv4 = ~clkdiv4;

   int cyc = 0;
   always @(posedge clkdiv4) cyc <= cyc + 1;

   // Pulse monitor: counts high cycles of each strobe and overlapping strobes.
   int n_valid = 0, n_keyup = 0, n_err = 0, excl = 0, last_err_cyc = 0;
   always @(negedge clkdiv4) begin
      if (valid)  n_valid <= n_valid + 1;
      if (key_up) n_keyup <= n_keyup + 1;
      if (frame_err) begin
         n_err        <= n_err + 1;
         last_err_cyc <= cyc;
      end
      if ((valid & key_up) | (valid & frame_err) | (key_up & frame_err))
         excl <= excl + 1;
   end

   int total = 0, bad = 0;
   int last_fall_cyc = 0;
   int sv, sk, se;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clkdiv4);
      #1;
   endtask

   task automatic send_bit(input logic b, input int half);
      ps2_data = b;
      wait_cyc(half);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip, input int half);
      logic p;
      p = (~^d) ^ flip;
      send_bit(1'b0, half);
      for (int i = 0; i < 8; i++) send_bit(d[i], half);
      send_bit(p, half);
      send_bit(1'b1, half);
      ps2_data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic snap();
      sv = n_valid;
      sk = n_keyup;
      se = n_err;
   endtask

   typedef struct {
      logic [7:0] data;
      bit         flip;
      int         half;
      int         ev, ek, ee;
      logic [7:0] code;
      bit         ext;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{8'h2B, 1'b0, 400, 1, 0, 0, 8'h2B, 1'b0};
      vecs[1] = '{8'hF0, 1'b0, 30,  0, 0, 0, 8'h2B, 1'b0};
      vecs[2] = '{8'h2B, 1'b0, 30,  0, 1, 0, 8'h2B, 1'b0};
      vecs[3] = '{8'hE0, 1'b0, 30,  0, 0, 0, 8'h2B, 1'b0};
      vecs[4] = '{8'h15, 1'b0, 30,  1, 0, 0, 8'h15, 1'b1};
      vecs[5] = '{8'h33, 1'b0, 30,  1, 0, 0, 8'h33, 1'b0};
      vecs[6] = '{8'h22, 1'b1, 30,  0, 0, 1, 8'h33, 1'b0};
      vecs[7] = '{8'h22, 1'b0, 30,  1, 0, 0, 8'h22, 1'b0};
      vecs[8] = '{8'h22, 1'b0, 30,  1, 0, 0, 8'h22, 1'b0};

      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(3);
      check("rst_scancode",  int'(scancode),  0);
      check("rst_valid",     int'(valid),     0);
      check("rst_key_up",    int'(key_up),    0);
      check("rst_extended",  int'(extended),  0);
      check("rst_frame_err", int'(frame_err), 0);
      reset = 1'b0;
      wait_cyc(10);

      for (int i = 0; i < 9; i++) begin
         snap();
         send_frame(vecs[i].data, vecs[i].flip, vecs[i].half);
         check($sformatf("v%0d_valid", i),    n_valid - sv, vecs[i].ev);
         check($sformatf("v%0d_key_up", i),   n_keyup - sk, vecs[i].ek);
         check($sformatf("v%0d_err", i),      n_err - se,   vecs[i].ee);
         check($sformatf("v%0d_scancode", i), int'(scancode), int'(vecs[i].code));
         check($sformatf("v%0d_extended", i), int'(extended), int'(vecs[i].ext));
      end

      // Short glitch while idle must not start a frame (else it would time out).
      snap();
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(TIMEOUT + 50);
      check("glitch_err", n_err - se, 0);

      // Partial frame (start + 4 bits) then silence.
      snap();
      send_bit(1'b0, 30);
      send_bit(1'b1, 30);
      send_bit(1'b0, 30);
      send_bit(1'b1, 30);
      send_bit(1'b0, 30);
      ps2_data = 1'b1;
      wait_cyc(TIMEOUT + 50);
      check("timeout_err", n_err - se, 1);
      check("timeout_valid", n_valid - sv, 0);
      check_range("timeout_delay", last_err_cyc - last_fall_cyc, TIMEOUT + 5, TIMEOUT + 9);
      check("timeout_scancode", int'(scancode), 8'h22);

      snap();
      send_frame(8'h15, 1'b0, 30);
      check("after_to_valid", n_valid - sv, 1);
      check("after_to_scancode", int'(scancode), 8'h15);
      check("after_to_extended", int'(extended), 0);

      // Reset after the 4th data bit of 0x2B.
      send_bit(1'b0, 30);
      send_bit(1'b1, 30);
      send_bit(1'b1, 30);
      send_bit(1'b0, 30);
      send_bit(1'b1, 30);
      reset = 1'b1;
      #2;
      check("midrst_async_scancode", int'(scancode), 0);
      wait_cyc(2);
      check("midrst_scancode",  int'(scancode),  0);
      check("midrst_valid",     int'(valid),     0);
      check("midrst_key_up",    int'(key_up),    0);
      check("midrst_extended",  int'(extended),  0);
      check("midrst_frame_err", int'(frame_err), 0);
      reset = 1'b0;
      wait_cyc(2);

      // Remaining bits D4..D7, parity, stop: D4=0 acts as a new start bit.
      snap();
      send_bit(1'b0, 30);
      send_bit(1'b1, 30);
      send_bit(1'b0, 30);
      send_bit(1'b0, 30);
      send_bit(1'b1, 30);
      send_bit(1'b1, 30);
      ps2_data = 1'b1;
      wait_cyc(TIMEOUT + 50);
      check("postrst_err", n_err - se, 1);
      check("postrst_valid", n_valid - sv, 0);
      check("postrst_scancode", int'(scancode), 0);

      snap();
      send_frame(8'h33, 1'b0, 30);
      check("final_valid", n_valid - sv, 1);
      check("final_err", n_err - se, 0);
      check("final_scancode", int'(scancode), 8'h33);

      check("strobe_exclusive", excl, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
